branch_predictor_pht: RTL and testbench

BRANCH_PREDICTOR_PHT -- requirements
Module: branch_predictor_pht

---
 rtl/bp_pkg.sv | 21 ++
 rtl/branch_predictor_pht_if.sv | 31 +++
 rtl/sat_counter2.sv | 15 +
 rtl/branch_predictor_pht.sv | 69 ++++++
 tb/tb_branch_predictor_pht.sv | 132 +++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared encodings for the pattern-history-table branch predictor:
// indexing schemes, the counter reset value and the branch opcode decode.
package bp_pkg;

  typedef enum logic [1:0] {
    SCH_BIMODAL = 2'd0,
    SCH_GLOBAL  = 2'd1,
    SCH_GSELECT = 2'd2,
    SCH_GSHARE  = 2'd3
  } scheme_e;

  localparam logic [1:0] CTR_RESET = 2'b01;

  // Conditional branches live in the 000xxx major opcode group.
  function automatic logic is_branch(input logic [5:0] op);
    return (op[5:3] == 3'b000) &&
           (op[2:0] == 3'b001 || op[2:0] == 3'b100 || op[2:0] == 3'b101 ||
            op[2:0] == 3'b110 || op[2:0] == 3'b111);
  endfunction

endpackage

// File: rtl/branch_predictor_pht_if.sv
// Lookup/update/prediction bundle between fetch/resolve logic and the PHT.
interface branch_predictor_pht_if #(
   parameter int ADDR_LENGTH = 22,
   parameter int DATA_WIDTH  = 32,
   parameter int INDEX_BITS  = 6
);
   logic                   i_lookup;
   logic [ADDR_LENGTH-1:0] i_IMEM_address;
   logic [DATA_WIDTH-1:0]  i_IMEM_inst;
   logic                   i_update_valid;
   logic [INDEX_BITS-1:0]  i_update_index;
   logic                   i_update_pred;
   logic                   i_outcome;
   logic                   o_taken;
   logic                   o_valid;
   logic [INDEX_BITS-1:0]  o_index;
   logic                   o_flush;
   logic [15:0]            o_mispredict_cnt;

   modport master (
      output i_lookup, i_IMEM_address, i_IMEM_inst,
             i_update_valid, i_update_index, i_update_pred, i_outcome,
      input  o_taken, o_valid, o_index, o_flush, o_mispredict_cnt
   );

   modport slave (
      input  i_lookup, i_IMEM_address, i_IMEM_inst,
             i_update_valid, i_update_index, i_update_pred, i_outcome,
      output o_taken, o_valid, o_index, o_flush, o_mispredict_cnt
   );
endinterface

// File: rtl/sat_counter2.sv
// Two-bit saturating counter next-state; holds the value when not enabled.
module sat_counter2 (
   input  logic [1:0] cnt,
   input  logic       en,
   input  logic       up,
   output logic [1:0] nxt
);
   always_comb begin
      nxt = cnt;
      if (en) begin
         if (up && cnt != 2'b11)       nxt = cnt + 2'd1;
         else if (!up && cnt != 2'b00) nxt = cnt - 2'd1;
      end
   end
endmodule

// File: rtl/branch_predictor_pht.sv
// Flop-based pattern history table predictor with selectable indexing scheme.
// Predictions read pre-update state; GHR advances only on resolved branches.
module branch_predictor_pht
   import bp_pkg::*;
#(
   parameter int ADDR_LENGTH = 22,
   parameter int DATA_WIDTH  = 32,
   parameter int INDEX_BITS  = 6,
   parameter int HIST_BITS   = 6,
   parameter int SCHEME      = 0
) (
   input logic                   i_Clk,
   input logic                   i_Reset,
   branch_predictor_pht_if.slave bus
);
   localparam int NUM_ENT = 1 << INDEX_BITS;
   localparam int HALF    = INDEX_BITS / 2;

   logic [NUM_ENT-1:0][1:0] pht, pht_nxt;
   logic [HIST_BITS-1:0]    ghr;
   logic [INDEX_BITS-1:0]   a, g, idx;
   logic                    br, mis;
   logic                    unused_bits;

   assign a   = bus.i_IMEM_address[INDEX_BITS-1:0];
   assign g   = INDEX_BITS'(ghr);
   assign br  = is_branch(bus.i_IMEM_inst[31:26]);
   assign mis = bus.i_update_valid && (bus.i_outcome != bus.i_update_pred);
   assign unused_bits = ^{bus.i_IMEM_address, bus.i_IMEM_inst[25:0]};

   always_comb begin
      idx = a;
      if (SCHEME == int'(SCH_GLOBAL))       idx = g;
      else if (SCHEME == int'(SCH_GSELECT)) idx = {g[HALF-1:0], a[INDEX_BITS-HALF-1:0]};
      else if (SCHEME == int'(SCH_GSHARE))  idx = a ^ g;
   end

   for (genvar e = 0; e < NUM_ENT; e++) begin : g_ent
      sat_counter2 u_ctr (
         .cnt (pht[e]),
         .en  (bus.i_update_valid && bus.i_update_index == INDEX_BITS'(e)),
         .up  (bus.i_outcome),
         .nxt (pht_nxt[e])
      );
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         pht                  <= {NUM_ENT{CTR_RESET}};
         ghr                  <= '0;
         bus.o_taken          <= 1'b0;
         bus.o_valid          <= 1'b0;
         bus.o_index          <= '0;
         bus.o_flush          <= 1'b0;
         bus.o_mispredict_cnt <= '0;
      end else begin
         pht         <= pht_nxt;
         bus.o_valid <= bus.i_lookup && br;
         bus.o_taken <= bus.i_lookup && pht[idx][1];
         bus.o_flush <= mis;
         if (bus.i_lookup)
            bus.o_index <= idx;
         if (bus.i_update_valid)
            ghr <= HIST_BITS'({ghr, bus.i_outcome});
         if (mis && bus.o_mispredict_cnt != 16'hFFFF)
            bus.o_mispredict_cnt <= bus.o_mispredict_cnt + 16'd1;
      end
   end
endmodule

// File: tb/tb_branch_predictor_pht.sv
// Drives a bimodal and a gshare predictor with identical stimulus and checks
// both against an integer reference model of counters, history and flushes.
module tb_branch_predictor_pht;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   branch_predictor_pht_if b0 ();
   branch_predictor_pht_if b3 ();

   branch_predictor_pht #(.SCHEME(0)) u_bim   (.i_Clk(clk), .i_Reset(rst), .bus(b0.slave));
   branch_predictor_pht #(.SCHEME(3)) u_gshare(.i_Clk(clk), .i_Reset(rst), .bus(b3.slave));

   int n_checks = 0;
   int n_errors = 0;

   int m_pht [64];
   int m_ghr, m_cnt;
   int e0_valid, e0_taken, e0_index, e3_valid, e3_taken, e3_index, e_flush;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int decode(input logic [31:0] inst);
      int op;
      op = int'(inst[31:26]);
      return (op == 1 || op == 4 || op == 5 || op == 6 || op == 7) ? 1 : 0;
   endfunction

   // One clock: apply inputs, advance the model, then compare on the next negedge.
   task automatic step(input logic r, input logic lk, input logic [21:0] addr,
                       input logic [31:0] inst, input logic uv, input logic [5:0] uidx,
                       input logic upred, input logic outc);
      int i0, i3;
      rst = r;
      b0.i_lookup = lk;        b3.i_lookup = lk;
      b0.i_IMEM_address = addr; b3.i_IMEM_address = addr;
      b0.i_IMEM_inst = inst;    b3.i_IMEM_inst = inst;
      b0.i_update_valid = uv;   b3.i_update_valid = uv;
      b0.i_update_index = uidx; b3.i_update_index = uidx;
      b0.i_update_pred = upred; b3.i_update_pred = upred;
      b0.i_outcome = outc;      b3.i_outcome = outc;
      if (r) begin
         foreach (m_pht[k]) m_pht[k] = 1;
         m_ghr = 0; m_cnt = 0;
         e0_valid = 0; e0_taken = 0; e0_index = 0;
         e3_valid = 0; e3_taken = 0; e3_index = 0; e_flush = 0;
      end else begin
         i0 = int'(addr[5:0]);
         i3 = i0 ^ m_ghr;
         e0_valid = lk ? decode(inst) : 0;
         e3_valid = e0_valid;
         e0_taken = (lk && m_pht[i0] >= 2) ? 1 : 0;
         e3_taken = (lk && m_pht[i3] >= 2) ? 1 : 0;
         if (lk) begin e0_index = i0; e3_index = i3; end
         e_flush = (uv && outc != upred) ? 1 : 0;
         if (uv) begin
            m_pht[uidx] = outc ? ((m_pht[uidx] + 1 > 3) ? 3 : m_pht[uidx] + 1)
                               : ((m_pht[uidx] - 1 < 0) ? 0 : m_pht[uidx] - 1);
            m_ghr = (m_ghr * 2 + int'(outc)) % 64;
         end
         if (e_flush == 1 && m_cnt < 65535) m_cnt++;
      end
      @(negedge clk);
      chk("bim_valid", 32'(b0.o_valid), 32'(e0_valid));
      chk("bim_taken", 32'(b0.o_taken), 32'(e0_taken));
      chk("bim_index", 32'(b0.o_index), 32'(e0_index));
      chk("gsh_valid", 32'(b3.o_valid), 32'(e3_valid));
      chk("gsh_taken", 32'(b3.o_taken), 32'(e3_taken));
      chk("gsh_index", 32'(b3.o_index), 32'(e3_index));
      chk("flush",     32'(b0.o_flush), 32'(e_flush));
      chk("flush3",    32'(b3.o_flush), 32'(e_flush));
      chk("mis_cnt",   32'(b0.o_mispredict_cnt), 32'(m_cnt));
   endtask

   localparam logic [31:0] BEQ = 32'h1000_0000;
   localparam logic [31:0] ALU = 32'h2000_0000;

   initial begin
      logic [31:0] inst;
      // Reset state
      step(1, 0, 0, 0, 0, 0, 0, 0);
      // Cold bimodal lookup of beq at 0x5
      step(0, 1, 22'h5, BEQ, 0, 0, 0, 0);
      chk("cold_idx", 32'(b0.o_index), 32'h5);
      // Two taken mispredicting updates to index 5, then lookup predicts taken
      step(0, 0, 0, 0, 1, 6'd5, 0, 1);
      step(0, 0, 0, 0, 1, 6'd5, 0, 1);
      chk("cnt_two", 32'(b0.o_mispredict_cnt), 32'd2);
      step(0, 1, 22'h5, BEQ, 0, 0, 0, 0);
      chk("trained", 32'(b0.o_taken), 32'd1);
      // Saturation at index 9: five taken, one not-taken keeps prediction
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 6'd9, 1, 1);
      step(0, 0, 0, 0, 1, 6'd9, 1, 0);
      step(0, 1, 22'h9, BEQ, 0, 0, 0, 0);
      chk("sat_taken", 32'(b0.o_taken), 32'd1);
      // Non-branch lookup
      step(0, 1, 22'h9, ALU, 0, 0, 0, 0);
      // Gshare: T,T,N history then lookup 0x3 -> index 0x5
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 6'd20, 1, 1);
      step(0, 0, 0, 0, 1, 6'd21, 1, 1);
      step(0, 0, 0, 0, 1, 6'd22, 0, 0);
      step(0, 1, 22'h3, BEQ, 0, 0, 0, 0);
      chk("gshare_idx", 32'(b3.o_index), 32'h5);
      // Collision: lookup and update of index 7 in the same cycle
      step(0, 1, 22'h7, BEQ, 1, 6'd7, 0, 1);
      chk("coll_old", 32'(b0.o_taken), 32'd0);
      step(0, 1, 22'h7, BEQ, 0, 0, 0, 0);
      chk("coll_new", 32'(b0.o_taken), 32'd1);
      // Reset with pending mispredicting update and lookup
      step(1, 1, 22'h7, BEQ, 1, 6'd7, 0, 1);
      chk("rst_flush", 32'(b0.o_flush), 32'd0);
      step(0, 1, 22'h7, BEQ, 0, 0, 0, 0);
      chk("rst_pht", 32'(b0.o_taken), 32'd0);
      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         inst = $urandom;
         if ($urandom_range(0, 3) != 0) inst[31:29] = 3'b000;
         step(($urandom_range(0, 99) == 0), $urandom_range(0, 1), 22'($urandom),
              inst, $urandom_range(0, 1), 6'($urandom_range(0, 15)),
              $urandom_range(0, 1), $urandom_range(0, 1));
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
